garbage_row_inserter: RTL and testbench

Counterpart to the row-elimination logic. It pushes garbage rows in from the bottom of the 10x20 static playfield and shifts every existing row upward, one row per clock. It is used for penalty or attack rows. The result is handed back as a complete 200-bit board, and the block flags any blocks pushed off the top so the game FSM can declare top-out.

---
 rtl/garbage_row_inserter_if.sv | 25 ++
 rtl/garbage_row_inserter.sv | 73 +++++++
 tb/tb_garbage_row_inserter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/garbage_row_inserter_if.sv
// Request/result bundle for the garbage row inserter.
// `static` is a reserved word, so the incoming board travels as static_board.
interface garbage_row_inserter_if #(
    parameter int COLS = 10,
    parameter int ROWS = 20
);
    logic                   start;
    logic [COLS*ROWS-1:0]   static_board;
    logic [2:0]             rows_req;
    logic [3:0]             hole_col;
    logic                   busy;
    logic                   done;
    logic                   overflow;
    logic [COLS*ROWS-1:0]   new_static;

    modport master (
        output start, static_board, rows_req, hole_col,
        input  busy, done, overflow, new_static
    );

    modport slave (
        input  start, static_board, rows_req, hole_col,
        output busy, done, overflow, new_static
    );
endinterface

// File: rtl/garbage_row_inserter.sv
// Pushes up to MAX_INS garbage rows in from the bottom of the playfield,
// one row per clock, and reports any occupied cells pushed off the top.
module garbage_row_inserter #(
    parameter int COLS    = 10,
    parameter int ROWS    = 20,
    parameter int MAX_INS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    garbage_row_inserter_if.slave   bus
);
    localparam int          BITS   = COLS * ROWS;
    localparam logic [2:0]  MAX_W  = 3'(MAX_INS);
    localparam logic [3:0]  COLS_W = 4'(COLS);

    typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

    state_t             state;
    logic [BITS-1:0]    work;
    logic [2:0]         cnt;
    logic [3:0]         hole;
    logic [2:0]         req_clamped;
    logic [3:0]         hole_clamped;
    logic [COLS-1:0]    garbage_row;

    always_comb begin
        req_clamped  = (bus.rows_req > MAX_W) ? MAX_W : bus.rows_req;
        hole_clamped = (bus.hole_col < COLS_W) ? bus.hole_col : 4'd0;
        garbage_row  = ~(COLS'(1) << hole);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            work           <= '0;
            cnt            <= '0;
            hole           <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.overflow   <= 1'b0;
            bus.new_static <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        work         <= bus.static_board;
                        cnt          <= req_clamped;
                        hole         <= hole_clamped;
                        bus.overflow <= 1'b0;
                        bus.busy     <= 1'b1;
                        state        <= (req_clamped != 3'd0) ? SHIFT : FIN;
                    end
                end
                SHIFT: begin
                    // Top row leaves the board on this shift; any set cell is a top-out.
                    bus.overflow <= bus.overflow | (|work[BITS-1 -: COLS]);
                    work         <= {work[BITS-COLS-1:0], garbage_row};
                    cnt          <= cnt - 3'd1;
                    if (cnt == 3'd1)
                        state <= FIN;
                end
                FIN: begin
                    bus.new_static <= work;
                    bus.done       <= 1'b1;
                    bus.busy       <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_garbage_row_inserter.sv
// Randomised scoreboard bench for garbage_row_inserter with a row-level reference model.
module tb_garbage_row_inserter;
    localparam int COLS = 10;
    localparam int ROWS = 20;
    localparam int BITS = COLS * ROWS;

    typedef struct {
        logic [BITS-1:0] board;
        logic            ovf;
        int unsigned     n;
        int unsigned     done_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int unsigned cyc = 0;
    int checks = 0;
    int failures = 0;
    int unsigned busy_cnt = 0;
    exp_t q[$];

    garbage_row_inserter_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

    garbage_row_inserter #(.COLS(COLS), .ROWS(ROWS), .MAX_INS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [BITS-1:0] act, input logic [BITS-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Result row r is garbage below the inserted count, else the old row r-n.
    function automatic exp_t model(input logic [BITS-1:0] b, input logic [2:0] req,
                                   input logic [3:0] hc, input int unsigned cyc_now);
        exp_t e;
        int unsigned n;
        int unsigned h;
        n = (req > 3'd4) ? 4 : int'(req);
        h = (hc < 4'd10) ? int'(hc) : 0;
        e.board = '0;
        e.ovf = 1'b0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (r < int'(n)) e.board[r*COLS+c] = (c != int'(h));
                else             e.board[r*COLS+c] = b[(r-int'(n))*COLS+c];
        for (int r = ROWS - int'(n); r < ROWS; r++)
            if (b[r*COLS +: COLS] != '0) e.ovf = 1'b1;
        e.n = n;
        e.done_cyc = cyc_now + n + 2;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: done at cycle %0d with nothing outstanding", cyc);
                end else begin
                    e = q.pop_front();
                    check("new_static", bus.new_static, e.board);
                    check("overflow", BITS'(bus.overflow), BITS'(e.ovf));
                    check("done_latency", BITS'(cyc), BITS'(e.done_cyc));
                    check("busy_cycles", BITS'(busy_cnt), BITS'(e.n + 1));
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic do_op(input logic [BITS-1:0] b, input logic [2:0] req, input logic [3:0] hc);
        @(negedge clk);
        bus.start = 1'b1;
        bus.static_board = b;
        bus.rows_req = req;
        bus.hole_col = hc;
        q.push_back(model(b, req, hc, cyc));
        @(negedge clk);
        bus.start = 1'b0;
        bus.static_board = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_idle();
        int unsigned t = 0;
        while (q.size() != 0 && t < 30) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: %0d operations still outstanding", q.size());
            q.delete();
        end
    endtask

    function automatic logic [BITS-1:0] rand_board();
        logic [BITS-1:0] b;
        b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return b;
    endfunction

    initial begin
        logic [BITS-1:0] b;
        bus.start = 1'b0;
        bus.static_board = '0;
        bus.rows_req = '0;
        bus.hole_col = '0;
        #12;
        check("reset_new_static", bus.new_static, '0);
        check("reset_flags", BITS'({bus.busy, bus.done, bus.overflow}), '0);
        rst_n = 1'b1;

        // Single insert
        b = '0; b[0] = 1'b1;
        do_op(b, 3'd1, 4'd3);
        wait_idle();
        check("single_insert_board", bus.new_static, BITS'(200'h7F7));

        // Clamp to four rows, out-of-range hole maps to column 0
        do_op('0, 3'd7, 4'd12);
        wait_idle();
        check("clamp_upper_rows", BITS'(bus.new_static[BITS-1:4*COLS]), '0);

        // Top-out
        b = '0; b[195] = 1'b1; b[185] = 1'b1;
        do_op(b, 3'd1, 4'd5);
        wait_idle();
        check("topout_flag", BITS'(bus.overflow), BITS'(1));
        check("topout_bit195", BITS'(bus.new_static[195]), BITS'(1));

        // Zero request
        b = rand_board();
        do_op(b, 3'd0, 4'd2);
        wait_idle();
        check("zero_req_board", bus.new_static, b);

        // start while busy is ignored
        do_op(rand_board(), 3'd3, 4'd7);
        @(negedge clk);
        bus.start = 1'b1;
        bus.rows_req = 3'd1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        repeat (8) @(negedge clk);

        // Reset after two of four shifts
        do_op(rand_board(), 3'd4, 4'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_new_static", bus.new_static, '0);
        check("abort_flags", BITS'({bus.busy, bus.done, bus.overflow}), '0);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(rand_board(), 3'd2, 4'd9);
        wait_idle();

        // Random traffic, occasionally poking start mid-operation
        for (int i = 0; i < 40; i++) begin
            b = rand_board();
            if ($urandom_range(0, 3) == 0) b[BITS-1:BITS-4*COLS] = '0;
            do_op(b, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 2) == 0) begin
                bus.start = 1'b1;
                bus.rows_req = 3'($urandom_range(0, 7));
                @(negedge clk);
                bus.start = 1'b0;
            end
            wait_idle();
        end

        repeat (10) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
